cm3_matrix_input_stage: RTL
===========================

Name: cm3_matrix_input_stage

Overview:
- AHB-Lite input stage that sits between one bus-matrix slave port (master side) and its address decoder.
- Passes each address phase straight through to the decoder when the selected output stage is free.
- When the output stage is busy serving another port (active_dec low), captures the address phase into a holding register and stalls the master until the output stage accepts it.
- Supplies the decoder with sel/addr/trans/ready, and returns HREADYOUT/HRESP to the master.

Parameters:
- DECODE_LSB, 10: lowest HADDR bit forwarded as addr_op; addr_op spans [31:DECODE_LSB].
- STALL_CNT_WIDTH, 16: width of the optional stall counter.

Ports:
- HCLK  in  1  AHB system clock
- HRESETn  in  1  asynchronous active-low reset
- HSELS  in  1  port select from the master
- HADDRS  in  32  master address
- HTRANSS  in  2  master HTRANS
- ctrl_s  in  12  {HMASTLOCK, HPROT[3:0], HBURST[2:0], HSIZE[2:0], HWRITE}
- HREADYS  in  1  master-side HREADY (transfer done)
- active_dec  in  1  decoder: target output stage is serving this port
- readyout_dec  in  1  decoder HREADYOUT (data phase)
- resp_dec  in  2  decoder HRESP (data phase)
- sel_op  out  1  HSEL to the decoder
- addr_op  out  32-DECODE_LSB  decode address to the decoder
- trans_op  out  2  HTRANS to the decoder and output stages
- ctrl_op  out  12  control bundle to the output stages
- ready_op  out  1  HREADY to the decoder (drives HREADYS there)
- held_tran_op  out  1  high while the holding register is the source
- HREADYOUTS  out  1  HREADYOUT to the master
- HRESPS  out  2  HRESP to the master
- stall_cnt  out  STALL_CNT_WIDTH  stall-cycle count

Behaviour:
- Single clock HCLK; reset asynchronous, active-low on HRESETn.
- Reset values: pend=0, holding register = 0, data_phase=0. Resulting outputs: HREADYOUTS=1, HRESPS=OKAY(00), sel_op=0, trans_op=IDLE, stall_cnt=0.
- tran_valid = HSELS & HTRANSS[1] & HREADYS.
- Capture: on tran_valid & ~active_dec, latch HSELS, HADDRS, HTRANSS and ctrl_s into the holding register and set pend=1 on the next edge.
- Source mux: when pend=1, sel_op/addr_op/trans_op/ctrl_op come from the holding register; otherwise they pass through combinationally from the master (zero latency). held_tran_op = pend.
- ready_op = pend ? active_dec : HREADYS. A held address phase completes on the edge where pend & active_dec are both high.
- pend clears on the same edge as pend & active_dec. A pending transfer is never dropped or reordered.
- data_phase:
  - set to 1 on any edge where ready_op=1 and an issued transfer was valid (sel_op & trans_op[1]);
  - cleared on any edge where ready_op=1 otherwise.
- HREADYOUTS:
  - 0 while pend;
  - readyout_dec during data_phase;
  - 1 otherwise.
- HRESPS:
  - resp_dec during data_phase and not pend;
  - OKAY otherwise.
  - A two-cycle ERROR from the decoder passes through unchanged.
- No new capture can occur while pend is set, because the master sees HREADYOUTS low; HREADYS=0 keeps the holding register stable.
- IDLE/BUSY transfers never set pend. HSELS low gives sel_op=0 and trans_op passes through.
- Simultaneous capture and active_dec=1 in the same cycle: no hold; the transfer passes through.
- Reset mid-hold: the pending transfer is discarded and all state returns to reset values.

Optional Feature:
- CM3_MATRIX_STALL_CNT_EN defined: stall_cnt increments once per cycle with pend=1, saturates at all-ones, and clears only on reset.
- Undefined: stall_cnt is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package cm3_matrix_pkg holds:
  - HTRANS encodings (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11);
  - HRESP OKAY/ERROR;
  - ctrl bundle field offsets and CTRL_W=12.
- One natural sub-module: cm3_matrix_hold_reg (holding register plus pend flag). Output muxing stays in the top level.

Test Plan:
- Pass-through: active_dec=1, NONSEQ to 0x40000010 -> same cycle sel_op=1, addr_op=0x100000, held_tran_op=0; data phase HREADYOUTS=readyout_dec.
- Hold: active_dec=0 on NONSEQ 0x20000400 write -> next cycle pend=1, HREADYOUTS=0, addr_op=0x080001. active_dec rises 3 cycles later -> pend clears, ready_op=1, then HRDATA phase follows.
- Error: held transfer issued, resp_dec=ERROR for 2 cycles with readyout_dec 0 then 1 -> HRESPS=ERROR both cycles, HREADYOUTS 0 then 1.
- IDLE/BUSY with active_dec=0 -> pend stays 0, HREADYOUTS=1.
- HRESETn low while pend=1 -> asynchronously pend=0, sel_op=0, HREADYOUTS=1.
- With CM3_MATRIX_STALL_CNT_EN defined, 5-cycle hold -> stall_cnt=5; force 2^16+3 stall cycles -> stall_cnt=0xFFFF.

Source files
------------

// File: rtl/cm3_matrix_pkg.sv
// Shared encodings for the bus-matrix input stage.
// HTRANS/HRESP values and the control bundle layout.
package cm3_matrix_pkg;

    localparam int CTRL_W         = 12;
    localparam int CTRL_WRITE     = 0;
    localparam int CTRL_SIZE_LSB  = 1;
    localparam int CTRL_BURST_LSB = 4;
    localparam int CTRL_PROT_LSB  = 7;
    localparam int CTRL_LOCK      = 11;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01
    } hresp_e;

    // NONSEQ and SEQ both carry a real transfer.
    function automatic logic is_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/cm3_matrix_hold_reg.sv
// Holding register for one stalled address phase plus its pend flag.
// A capture always wins over a release; the top never asks for both.
module cm3_matrix_hold_reg
    import cm3_matrix_pkg::*;
#(
    parameter int ADDR_W = 22
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              capture,
    input  logic              release_hold,
    input  logic              sel_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [1:0]        trans_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              pend,
    output logic              hold_sel,
    output logic [ADDR_W-1:0] hold_addr,
    output logic [1:0]        hold_trans,
    output logic [CTRL_W-1:0] hold_ctrl
);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend       <= 1'b0;
            hold_sel   <= 1'b0;
            hold_addr  <= '0;
            hold_trans <= TRANS_IDLE;
            hold_ctrl  <= '0;
        end else if (capture) begin
            pend       <= 1'b1;
            hold_sel   <= sel_in;
            hold_addr  <= addr_in;
            hold_trans <= trans_in;
            hold_ctrl  <= ctrl_in;
        end else if (release_hold) begin
            pend       <= 1'b0;
        end
    end

endmodule

// File: rtl/cm3_matrix_input_stage.sv
// AHB-Lite bus-matrix input stage: pass-through or hold-and-stall.
// Define CM3_MATRIX_STALL_CNT_EN to build the saturating stall counter.
module cm3_matrix_input_stage
    import cm3_matrix_pkg::*;
#(
    parameter int DECODE_LSB      = 10,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       HSELS,
    input  logic [31:0]                HADDRS,
    input  logic [1:0]                 HTRANSS,
    input  logic [CTRL_W-1:0]          ctrl_s,
    input  logic                       HREADYS,
    input  logic                       active_dec,
    input  logic                       readyout_dec,
    input  logic [1:0]                 resp_dec,
    output logic                       sel_op,
    output logic [31-DECODE_LSB:0]     addr_op,
    output logic [1:0]                 trans_op,
    output logic [CTRL_W-1:0]          ctrl_op,
    output logic                       ready_op,
    output logic                       held_tran_op,
    output logic                       HREADYOUTS,
    output logic [1:0]                 HRESPS,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

    localparam int ADDR_W = 32 - DECODE_LSB;

    logic              pend;
    logic              hold_sel;
    logic [ADDR_W-1:0] hold_addr;
    logic [1:0]        hold_trans;
    logic [CTRL_W-1:0] hold_ctrl;
    logic              tran_valid;
    logic              capture;
    logic              release_hold;
    logic              data_phase;

    logic [DECODE_LSB-1:0] unused_addr_lsb;
    assign unused_addr_lsb = HADDRS[DECODE_LSB-1:0];

    assign tran_valid   = HSELS & is_active(HTRANSS) & HREADYS;
    // The master is stalled while pend, so a second capture cannot occur.
    assign capture      = tran_valid & ~active_dec & ~pend;
    assign release_hold = pend & active_dec;

    cm3_matrix_hold_reg #(
        .ADDR_W (ADDR_W)
    ) u_hold (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .capture      (capture),
        .release_hold (release_hold),
        .sel_in       (HSELS),
        .addr_in      (HADDRS[31:DECODE_LSB]),
        .trans_in     (HTRANSS),
        .ctrl_in      (ctrl_s),
        .pend         (pend),
        .hold_sel     (hold_sel),
        .hold_addr    (hold_addr),
        .hold_trans   (hold_trans),
        .hold_ctrl    (hold_ctrl)
    );

    always_comb begin
        sel_op   = HSELS;
        addr_op  = HADDRS[31:DECODE_LSB];
        trans_op = HTRANSS;
        ctrl_op  = ctrl_s;
        ready_op = HREADYS;
        if (pend) begin
            sel_op   = hold_sel;
            addr_op  = hold_addr;
            trans_op = hold_trans;
            ctrl_op  = hold_ctrl;
            ready_op = active_dec;
        end
    end

    assign held_tran_op = pend;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_phase <= 1'b0;
        end else if (ready_op) begin
            data_phase <= sel_op & is_active(trans_op);
        end
    end

    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = RESP_OKAY;
        if (pend) begin
            HREADYOUTS = 1'b0;
        end else if (data_phase) begin
            HREADYOUTS = readyout_dec;
            HRESPS     = resp_dec;
        end
    end

`ifdef CM3_MATRIX_STALL_CNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_q;
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stall_q <= '0;
        end else if (pend && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_ONE;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
